// File: rtl/ntt_pkg.sv
// ntt_pkg
//   Shared definitions for the NTT bank scheduler and its helpers:
//   - scheduler FSM state encoding (IDLE / ISSUE / DRAIN)
//   - default geometry (bank address width, depth, stage count, BFU latency)
//   - tw_mask(): twiddle-index mask for a given stage
package ntt_pkg;

  localparam int ADDR_WIDTH_DEF = 6;
  localparam int DEPTH_DEF      = 64;
  localparam int STAGES_DEF     = 6;
  localparam int PIPE_LAT_DEF   = 4;

  // Width of the stage index output.
  localparam int STAGE_W = 3;

  // Widest twiddle index the mask helper supports.
  localparam int TW_MAX_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_t;

  // Mask that clears the low (aw-1-stg) bits of an index. At stage 0 only
  // the MSB survives; at stage aw-1 the index passes through unchanged.
  function automatic logic [TW_MAX_W-1:0] tw_mask(input logic [STAGE_W-1:0] stg,
                                                  input int aw);
    int clr;
    clr = aw - 1 - int'(stg);
    if (clr < 0) clr = 0;
    return {TW_MAX_W{1'b1}} << clr;
  endfunction

endpackage

// File: rtl/ntt_sched_delay_line.sv
// ntt_sched_delay_line
//   Fixed-length shift register of {valid, data} entries with a hold enable.
//   An entry presented on in_valid/in_data appears on out_valid/out_data
//   exactly LEN non-held cycles later. While hold is high every entry keeps
//   its value. Used to align bank write addresses with BFU results, and
//   equally usable for twiddle alignment.
// Parameters
//   WIDTH  data width
//   LEN    number of entries (>=1)
// Ports
//   clk        clock, posedge
//   rst_n      asynchronous active-low reset; clears all entries
//   hold       freeze all entries
//   in_valid   valid bit entering the line
//   in_data    data entering the line
//   out_valid  valid bit leaving the line
//   out_data   data leaving the line
module ntt_sched_delay_line #(
  parameter int WIDTH = 6,
  parameter int LEN   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  // Each tap holds {valid, data}.
  logic [LEN-1:0][WIDTH:0] tap_reg;
  logic [WIDTH:0]          tap_next [LEN];

  genvar gi;
  generate
    for (gi = 0; gi < LEN; gi++) begin : g_tap
      if (gi == 0) begin : g_head
        assign tap_next[gi] = {in_valid, in_data};
      end else begin : g_body
        assign tap_next[gi] = tap_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_reg <= '0;
    end else if (!hold) begin
      for (int i = 0; i < LEN; i++) begin
        tap_reg[i] <= tap_next[i];
      end
    end
  end

  assign out_valid = tap_reg[LEN-1][WIDTH];
  assign out_data  = tap_reg[LEN-1][WIDTH-1:0];

endmodule

// File: rtl/ntt_bank_scheduler.sv
// ntt_bank_scheduler
//   Sequences one forward NTT pass over a ping-pong pair of bank sets.
//   Each stage streams read addresses 0..DEPTH-1 to the source set, delays
//   them by PIPE_LAT+1 cycles (bank read + BFU latency) and presents them as
//   write addresses to the destination set. The next stage starts only after
//   every write of the current stage has left the delay line, because it
//   reads the set that was just written. A twiddle-ROM index is produced in
//   step with the read address.
// Optional feature
//   NTT_SCHED_PERF_CNT_EN : adds cyc_cnt, a saturating count of busy,
//                           non-stalled cycles, cleared on an accepted start.
// Parameters
//   ADDR_WIDTH  bank address width (log2 of DEPTH)
//   DEPTH       words per bank, 2**ADDR_WIDTH
//   STAGES      stages per pass, 1..ADDR_WIDTH
//   PIPE_LAT    BFU latency in cycles, >=1
// Ports
//   clk       clock, posedge
//   rst_n     asynchronous active-low reset; aborts a pass without done
//   start     one-cycle start pulse; honoured only when idle
//   stall     level freeze request from downstream
//   bank_en   EN to all banks (busy and not stalled)
//   ren       REN to source set
//   raddr     read address to source set
//   wen       WEN to destination set
//   waddr     write address to destination set
//   src_sel   source set index; destination is ~src_sel
//   tw_addr   twiddle index aligned with raddr
//   stage     current stage index
//   busy      pass in progress
//   done      one-cycle pulse when a pass completes
//   cyc_cnt   (optional) performance counter
module ntt_bank_scheduler
  import ntt_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int STAGES     = STAGES_DEF,
  parameter int PIPE_LAT   = PIPE_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stall,
  output logic                  bank_en,
  output logic                  ren,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  src_sel,
  output logic [ADDR_WIDTH-1:0] tw_addr,
  output logic [STAGE_W-1:0]    stage,
  output logic                  busy,
  output logic                  done
`ifdef NTT_SCHED_PERF_CNT_EN
  ,
  output logic [15:0]           cyc_cnt
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_K     = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [STAGE_W-1:0]    LAST_STAGE = STAGE_W'(STAGES - 1);
  // The drain counter runs 0..PIPE_LAT, one count per delay-line entry.
  localparam int                    DCW        = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);
  localparam logic [DCW-1:0]        DRAIN_LAST = DCW'(PIPE_LAT);

  sched_state_t          state_reg;
  logic [ADDR_WIDTH-1:0] k_reg;
  logic [STAGE_W-1:0]    stage_reg;
  logic                  src_sel_reg;
  logic [DCW-1:0]        drain_cnt_reg;
  logic                  done_reg;

  logic                  issuing;
  logic                  busy_w;
  logic                  start_ok;
  logic                  dl_hold;
  logic                  dl_valid;
  logic [ADDR_WIDTH-1:0] dl_addr;

  assign issuing  = (state_reg == ST_ISSUE);
  assign busy_w   = (state_reg != ST_IDLE);
  // A start landing on the done cycle belongs to the pass that just ended.
  assign start_ok = (state_reg == ST_IDLE) && start && !done_reg;
  // Stall only matters during a pass; in idle the line just flushes zeros.
  assign dl_hold  = stall && busy_w;

  // ---------------------------------------------------------------------
  // Pass/stage sequencer. Stall freezes every piece of state in here.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      k_reg         <= '0;
      stage_reg     <= '0;
      src_sel_reg   <= 1'b0;
      drain_cnt_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start_ok) begin
            state_reg   <= ST_ISSUE;
            k_reg       <= '0;
            stage_reg   <= '0;
            src_sel_reg <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (!stall) begin
            if (k_reg == LAST_K) begin
              k_reg         <= '0;
              drain_cnt_reg <= '0;
              state_reg     <= ST_DRAIN;
            end else begin
              k_reg <= k_reg + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (!stall) begin
            // The last count is the cycle the final write leaves the line.
            if (drain_cnt_reg == DRAIN_LAST) begin
              drain_cnt_reg <= '0;
              if (stage_reg == LAST_STAGE) begin
                state_reg   <= ST_IDLE;
                stage_reg   <= '0;
                src_sel_reg <= 1'b0;
                done_reg    <= 1'b1;
              end else begin
                state_reg   <= ST_ISSUE;
                stage_reg   <= stage_reg + 1'b1;
                src_sel_reg <= ~src_sel_reg;
              end
            end else begin
              drain_cnt_reg <= drain_cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Read-to-write alignment: PIPE_LAT+1 entries so a write lands exactly
  // PIPE_LAT+1 cycles after its read.
  // ---------------------------------------------------------------------
  ntt_sched_delay_line #(
    .WIDTH (ADDR_WIDTH),
    .LEN   (PIPE_LAT + 1)
  ) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold      (dl_hold),
    .in_valid  (issuing),
    .in_data   (k_reg),
    .out_valid (dl_valid),
    .out_data  (dl_addr)
  );

  // ---------------------------------------------------------------------
  // Outputs. Strobes are gated by stall in the same cycle; addresses come
  // straight from frozen state so they hold through a stall.
  // ---------------------------------------------------------------------
  assign busy    = busy_w;
  assign bank_en = busy_w && !stall;
  assign ren     = issuing && !stall;
  assign raddr   = k_reg;
  assign wen     = dl_valid && !stall;
  assign waddr   = dl_addr;
  assign src_sel = src_sel_reg;
  assign stage   = stage_reg;
  assign done    = done_reg;
  assign tw_addr = k_reg & ADDR_WIDTH'(tw_mask(stage_reg, ADDR_WIDTH));

`ifdef NTT_SCHED_PERF_CNT_EN
  logic [15:0] cyc_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_reg <= '0;
    end else if (start_ok) begin
      cyc_cnt_reg <= '0;
    end else if (busy_w && !stall && (cyc_cnt_reg != 16'hFFFF)) begin
      cyc_cnt_reg <= cyc_cnt_reg + 16'd1;
    end
  end

  assign cyc_cnt = cyc_cnt_reg;
`endif

endmodule

// File: tb/tb_ntt_bank_scheduler.sv
// tb_ntt_bank_scheduler
//   Self-checking bench for ntt_bank_scheduler (DEPTH=64, PIPE_LAT=4,
//   STAGES=6). The reference model tracks a pass as a count of productive
//   (non-stalled) cycles since start; every expected output is derived from
//   that position with plain division/modulo arithmetic.
//   Define NTT_SCHED_PERF_CNT_EN to also check cyc_cnt.
module tb_ntt_bank_scheduler;

  localparam int AW        = 6;
  localparam int DEPTH     = 64;
  localparam int STAGES    = 6;
  localparam int PIPE_LAT  = 4;
  localparam int WLAT      = PIPE_LAT + 1;       // read-to-write distance
  localparam int STAGE_LEN = DEPTH + WLAT;       // 69 productive cycles/stage
  localparam int PASS_LEN  = STAGES * STAGE_LEN; // 414 productive cycles/pass

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic          bank_en, ren, wen, src_sel, busy, done;
  logic [AW-1:0] raddr, waddr, tw_addr;
  logic [2:0]    stage;
`ifdef NTT_SCHED_PERF_CNT_EN
  logic [15:0]   cyc_cnt;
`endif

  ntt_bank_scheduler #(
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .STAGES     (STAGES),
    .PIPE_LAT   (PIPE_LAT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stall   (stall),
    .bank_en (bank_en),
    .ren     (ren),
    .raddr   (raddr),
    .wen     (wen),
    .waddr   (waddr),
    .src_sel (src_sel),
    .tw_addr (tw_addr),
    .stage   (stage),
    .busy    (busy),
    .done    (done)
`ifdef NTT_SCHED_PERF_CNT_EN
    ,
    .cyc_cnt (cyc_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state
  bit m_run;   // pass in progress
  int m_act;   // productive cycles completed in this pass
  bit m_done;  // done pulse expected this cycle
  int m_cnt;   // expected performance count

  int done_cnt;
  int done_cyc;
  int base;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    int p, stg, off, k, c;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (m_run) begin
      p   = m_act;
      stg = p / STAGE_LEN;
      off = p % STAGE_LEN;
      k   = (off < DEPTH) ? off : 0;
      c   = AW - 1 - stg;
      chk("busy",    busy,    1);
      chk("bank_en", bank_en, 32'(!stall));
      chk("ren",     ren,     32'(!stall && off < DEPTH));
      chk("raddr",   raddr,   k);
      chk("tw_addr", tw_addr, (k / (1 << c)) * (1 << c));
      chk("stage",   stage,   stg);
      chk("src_sel", src_sel, stg % 2);
      chk("wen",     wen,     32'(!stall && off >= WLAT));
      if (off >= WLAT) chk("waddr", waddr, off - WLAT);
      chk("done",    done,    0);
    end else begin
      chk("idle_busy",    busy,    0);
      chk("idle_bank_en", bank_en, 0);
      chk("idle_ren",     ren,     0);
      chk("idle_wen",     wen,     0);
      chk("idle_stage",   stage,   0);
      chk("idle_src_sel", src_sel, 0);
      chk("idle_done",    done,    32'(m_done));
    end
`ifdef NTT_SCHED_PERF_CNT_EN
    chk("cyc_cnt", cyc_cnt, m_cnt);
`endif
  endtask

  task automatic model_step();
    bit nd;
    nd = 1'b0;
    if (m_run) begin
      if (!stall) begin
        m_act++;
        if (m_cnt < 65535) m_cnt++;
      end
      if (m_act == PASS_LEN) begin
        m_run = 1'b0;
        nd    = 1'b1;
      end
    end else if (start && !m_done) begin
      m_run = 1'b1;
      m_act = 0;
      m_cnt = 0;
    end
    m_done = nd;
  endtask

  // One clock cycle: drive inputs after the edge, check mid-cycle, advance.
  task automatic tick(input bit st, input bit sl);
    @(posedge clk);
    #1;
    start = st;
    stall = sl;
    @(negedge clk);
    check_outputs();
    model_step();
    cyc++;
  endtask

  // Reset asserted away from any clock edge; outputs must clear at once.
  task automatic apply_reset();
    @(negedge clk);
    #2;
    start = 1'b0;
    stall = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_busy",    busy,    0);
    chk("rst_bank_en", bank_en, 0);
    chk("rst_ren",     ren,     0);
    chk("rst_raddr",   raddr,   0);
    chk("rst_wen",     wen,     0);
    chk("rst_waddr",   waddr,   0);
    chk("rst_src_sel", src_sel, 0);
    chk("rst_tw_addr", tw_addr, 0);
    chk("rst_stage",   stage,   0);
    chk("rst_done",    done,    0);
`ifdef NTT_SCHED_PERF_CNT_EN
    chk("rst_cyc_cnt", cyc_cnt, 0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    m_run  = 1'b0;
    m_act  = 0;
    m_done = 1'b0;
    m_cnt  = 0;
  endtask

  initial begin
    bit st, sl;
    int stall_left;

    apply_reset();
    repeat (3) tick(1'b0, 1'b0);

    // Clean pass, with stray starts mid-pass and on the done cycle.
    base = cyc; done_cnt = 0; done_cyc = -1;
    for (int i = 0; i < 430; i++) tick(i == 0 || i == 30 || i == 415, 1'b0);
    chk("clean_done_cycle", done_cyc - base, 415);
    chk("clean_done_count", done_cnt, 1);

    // Ten-cycle stall early in stage 0 shifts completion by ten cycles.
    base = cyc; done_cnt = 0; done_cyc = -1;
    for (int i = 0; i < 440; i++) tick(i == 0, i >= 20 && i <= 29);
    chk("stall_done_cycle", done_cyc - base, 425);
    chk("stall_done_count", done_cnt, 1);
`ifdef NTT_SCHED_PERF_CNT_EN
    chk("stall_cyc_cnt", cyc_cnt, 414);
`endif

    // Reset mid-pass: no done afterwards.
    done_cnt = 0;
    for (int i = 0; i < 100; i++) tick(i == 0, 1'b0);
    apply_reset();
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0);
    chk("abort_no_done", done_cnt, 0);

    // Start coinciding with stall while idle is still accepted.
    base = cyc; done_cnt = 0; done_cyc = -1;
    for (int i = 0; i < 420; i++) tick(i == 0, i == 0);
    chk("stall_start_done_cycle", done_cyc - base, 415);
    chk("stall_start_done_count", done_cnt, 1);

    // Random starts and bursty stalls.
    stall_left = 0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 900; i++) begin
        st = ($urandom_range(0, 40) == 0);
        if (stall_left > 0) begin
          sl = 1'b1;
          stall_left--;
        end else if ($urandom_range(0, 30) == 0) begin
          sl = 1'b1;
          stall_left = $urandom_range(0, 7);
        end else begin
          sl = 1'b0;
        end
        tick(st, sl);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
